// File: rtl/equal_const_pkg.sv
// rtl/equal_const_pkg.sv - shared constants and helpers for the equal_const comparator
package equal_const_pkg;

   localparam int GROUP_BITS = 6;
   localparam int TREE_FANIN = 4;

   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/equal_const_if.sv
// rtl/equal_const_if.sv - data word in, combinational and registered match out
interface equal_const_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] dat;
   logic             out;
   logic             out_reg;

   modport master (output dat, input out, input out_reg);
   modport slave  (input dat, output out, output out_reg);
endinterface

// File: rtl/equal_const_and_tree.sv
// rtl/equal_const_and_tree.sv - balanced AND reduction built from FANIN-input leaves
module and_tree_reduce
   import equal_const_pkg::*;
#(
   parameter int N     = 4,
   parameter int FANIN = TREE_FANIN
) (
   input  logic [N-1:0] in,
   output logic         out
);

   if (N <= FANIN) begin : g_leaf_only
      assign out = &in;
   end else begin : g_level
      localparam int M = ceil_div(N, FANIN);
      logic [M-1:0] stage;

      for (genvar i = 0; i < M; i++) begin : g_node
         localparam int LO = i * FANIN;
         localparam int HI = (LO + FANIN > N) ? N - 1 : LO + FANIN - 1;
         assign stage[i] = &in[HI:LO];
      end

      // Each level shrinks the width by FANIN until one leaf covers the rest.
      and_tree_reduce #(.N(M), .FANIN(FANIN)) u_next (
         .in  (stage),
         .out (out)
      );
   end

endmodule

// File: rtl/equal_const.sv
// rtl/equal_const.sv - compare dat against a constant; flat or chunked-LUT method
module equal_const
   import equal_const_pkg::*;
#(
   parameter int               WIDTH     = 10,
   parameter logic [WIDTH-1:0] CONST_VAL = 10'b1010111010,
   parameter int               METHOD    = 0
) (
   input  logic          clk,
   input  logic          rst,
   equal_const_if.slave  bus
);

   localparam logic [WIDTH-1:0] K = CONST_VAL;

   logic match;
   logic match_q;

   if (METHOD == 0) begin : g_flat
      assign match = (bus.dat == K);
   end else if (METHOD == 1) begin : g_chunked
      localparam int G = ceil_div(WIDTH, GROUP_BITS);
      logic [G-1:0] grp_eq;

      // LSB-first groups; the top group is narrower when WIDTH % 6 != 0.
      for (genvar g = 0; g < G; g++) begin : g_grp
         localparam int LO = g * GROUP_BITS;
         localparam int HI = (LO + GROUP_BITS > WIDTH) ? WIDTH - 1 : LO + GROUP_BITS - 1;
         assign grp_eq[g] = (bus.dat[HI:LO] == K[HI:LO]);
      end

      if (G == 1) begin : g_single
         assign match = grp_eq[0];
      end else begin : g_tree
         and_tree_reduce #(.N(G), .FANIN(TREE_FANIN)) u_tree (
            .in  (grp_eq),
            .out (match)
         );
      end
   end else begin : g_bad_method
      $error("equal_const: METHOD must be 0 or 1");
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match;
      end
   end

   assign bus.out     = match;
   assign bus.out_reg = match_q;

endmodule

// File: tb/tb_equal_const.sv
// tb/tb_equal_const.sv - randomized and directed checks of equal_const against a value model
module tb_equal_const;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   equal_const_if #(.WIDTH(10)) bus_a ();
   equal_const_if #(.WIDTH(10)) bus_b ();
   equal_const_if #(.WIDTH(1))  bus_c ();
   equal_const_if #(.WIDTH(1))  bus_d ();
   equal_const_if #(.WIDTH(13)) bus_e ();
   equal_const_if #(.WIDTH(13)) bus_f ();

   equal_const #(.WIDTH(10), .CONST_VAL(10'b1010111010), .METHOD(0)) u_a (.clk(clk), .rst(rst), .bus(bus_a));
   equal_const #(.WIDTH(10), .CONST_VAL(10'b1010111010), .METHOD(1)) u_b (.clk(clk), .rst(rst), .bus(bus_b));
   equal_const #(.WIDTH(1),  .CONST_VAL(1'b1),           .METHOD(0)) u_c (.clk(clk), .rst(rst), .bus(bus_c));
   equal_const #(.WIDTH(1),  .CONST_VAL(1'b1),           .METHOD(1)) u_d (.clk(clk), .rst(rst), .bus(bus_d));
   equal_const #(.WIDTH(13), .CONST_VAL(13'h1ABC),       .METHOD(0)) u_e (.clk(clk), .rst(rst), .bus(bus_e));
   equal_const #(.WIDTH(13), .CONST_VAL(13'h1ABC),       .METHOD(1)) u_f (.clk(clk), .rst(rst), .bus(bus_f));

   localparam int C10 = 698;   // 10'b1010111010
   localparam int C13 = 6844;  // 13'h1ABC

   // Reference: the word matches iff its value modulo 2**w equals the constant's.
   function automatic logic ref_eq(input int d, input int c, input int w);
      return ((d % (1 << w)) == (c % (1 << w))) ? 1'b1 : 1'b0;
   endfunction

   task automatic drive_all(input int d);
      logic [31:0] v;
      v = d;
      bus_a.dat = v[9:0];
      bus_b.dat = v[9:0];
      bus_c.dat = v[0];
      bus_d.dat = v[0];
      bus_e.dat = v[12:0];
      bus_f.dat = v[12:0];
   endtask

   task automatic test_reset();
      drive_all(C10);
      rst = 1'b1;
      #1;
      n_cmp++;
      if (bus_a.out !== 1'b1 || bus_b.out !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_comb_out: got %b/%b want 1/1", bus_a.out, bus_b.out);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (bus_a.out_reg !== 1'b0 || bus_b.out_reg !== 1'b0 || bus_e.out_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_reg cyc%0d: got %b/%b/%b want 0/0/0", i, bus_a.out_reg, bus_b.out_reg, bus_e.out_reg);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus_a.out_reg !== 1'b1 || bus_b.out_reg !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release: got %b/%b want 1/1", bus_a.out_reg, bus_b.out_reg);
      end
   endtask

   task automatic test_patterns();
      int pats[3] = '{C10, C10 ^ 1, C10 ^ 512};
      logic e;
      for (int i = 0; i < 3; i++) begin
         drive_all(pats[i]);
         e = ref_eq(pats[i], C10, 10);
         #1;
         n_cmp++;
         if (bus_a.out !== e || bus_b.out !== e) begin
            n_fail++;
            $display("FAIL pattern_out %03x: got %b/%b want %b", pats[i], bus_a.out, bus_b.out, e);
         end
         @(posedge clk); #1;
         n_cmp++;
         if (bus_a.out_reg !== e || bus_b.out_reg !== e) begin
            n_fail++;
            $display("FAIL pattern_out_reg %03x: got %b/%b want %b", pats[i], bus_a.out_reg, bus_b.out_reg, e);
         end
      end
   endtask

   task automatic test_random();
      int d;
      logic e10, e13, p10, p13;
      int hits = 0;
      p10 = bus_a.out;
      p13 = bus_e.out;
      for (int i = 0; i < 1000; i++) begin
         d = int'($urandom_range(0, 8191));
         if (i % 97 == 5)  d = C10;
         if (i % 89 == 11) d = C13;
         drive_all(d);
         e10 = ref_eq(d, C10, 10);
         e13 = ref_eq(d, C13, 13);
         if (e10) hits++;
         #1;
         n_cmp++;
         if (bus_a.out !== e10 || bus_b.out !== e10 || bus_a.out !== bus_b.out) begin
            n_fail++;
            $display("FAIL random_w10 %04x: got %b/%b want %b", d, bus_a.out, bus_b.out, e10);
         end
         n_cmp++;
         if (bus_e.out !== e13 || bus_f.out !== e13) begin
            n_fail++;
            $display("FAIL random_w13 %04x: got %b/%b want %b", d, bus_e.out, bus_f.out, e13);
         end
         // out_reg is sampled before the edge, so it still holds the previous word's match.
         n_cmp++;
         if (bus_a.out_reg !== p10 || bus_f.out_reg !== p13) begin
            n_fail++;
            $display("FAIL random_out_reg %0d: got %b/%b want %b/%b", i, bus_a.out_reg, bus_f.out_reg, p10, p13);
         end
         @(posedge clk); #1;
         p10 = e10;
         p13 = e13;
      end
      n_cmp++;
      if (hits < 1) begin
         n_fail++;
         $display("FAIL random_hits: got %0d want >=1", hits);
      end
   endtask

   task automatic test_boundary_width();
      int d;
      for (int v = 0; v < 2; v++) begin
         drive_all(v);
         #1;
         n_cmp++;
         if (bus_c.out !== ref_eq(v, 1, 1) || bus_d.out !== ref_eq(v, 1, 1)) begin
            n_fail++;
            $display("FAIL width1 dat=%0d: got %b/%b want %b", v, bus_c.out, bus_d.out, ref_eq(v, 1, 1));
         end
      end
      drive_all(C13);
      #1;
      n_cmp++;
      if (bus_e.out !== 1'b1 || bus_f.out !== 1'b1) begin
         n_fail++;
         $display("FAIL width13_hit: got %b/%b want 1/1", bus_e.out, bus_f.out);
      end
      for (int b = 0; b < 13; b++) begin
         d = C13 ^ (1 << b);
         drive_all(d);
         #1;
         n_cmp++;
         if (bus_e.out !== 1'b0 || bus_f.out !== 1'b0) begin
            n_fail++;
            $display("FAIL width13_flip bit%0d: got %b/%b want 0/0", b, bus_e.out, bus_f.out);
         end
      end
   endtask

   task automatic test_sweep();
      int ones_a = 0;
      int ones_b = 0;
      int where_a = -1;
      int where_b = -1;
      for (int v = 0; v < 1024; v++) begin
         drive_all(v);
         #1;
         if (bus_a.out === 1'b1) begin ones_a++; where_a = v; end
         if (bus_b.out === 1'b1) begin ones_b++; where_b = v; end
         n_cmp++;
         if (bus_a.out !== ref_eq(v, C10, 10) || bus_b.out !== ref_eq(v, C10, 10)) begin
            n_fail++;
            $display("FAIL sweep %03x: got %b/%b want %b", v, bus_a.out, bus_b.out, ref_eq(v, C10, 10));
         end
      end
      n_cmp++;
      if (ones_a != 1 || ones_b != 1 || where_a != 'h2BA || where_b != 'h2BA) begin
         n_fail++;
         $display("FAIL sweep_unique: got %0d@%0h/%0d@%0h want 1@2ba", ones_a, where_a, ones_b, where_b);
      end
   endtask

   task automatic test_mid_reset();
      drive_all(C10);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if (bus_a.out_reg !== 1'b0 || bus_b.out_reg !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: got %b/%b want 0/0", bus_a.out_reg, bus_b.out_reg);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (bus_a.out_reg !== 1'b1 || bus_b.out_reg !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_release: got %b/%b want 1/1", bus_a.out_reg, bus_b.out_reg);
      end
   endtask

   initial begin
      drive_all(0);
      test_reset();
      test_patterns();
      test_random();
      test_boundary_width();
      test_sweep();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
